// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the 8N1 UART transmitter: FSM encoding, frame width and
// default bit-time divisors for a 50 MHz system clock.
package uart_transmitter_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int CLK_DIV_115200_50M = 434;
  localparam int CLK_DIV_9600_50M   = 5208;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_fifo.sv
// Synchronous FIFO for the transmitter. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate count register.
module uart_transmitter_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Overflowing pushes and underflowing pops are ignored here as a last line of defence.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a divider-paced START/DATA/STOP
// serialiser. The current FSM state is exported on o_dbg_state.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_115200_50M,
  parameter int FIFO_AW   = 2,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_x,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_error,
  output tx_state_e                 o_dbg_state
);

  localparam int                DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, err_q;
  logic                      strobe, pop, push;
  logic                      fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  // Handshake: a byte is taken at a clock edge where i_valid && o_ready. o_ready is
  // !full from registered pointers only, so a pop never frees a slot in the same cycle.
  // i_valid while !o_ready drops the byte and sets the sticky o_error.
  assign o_ready     = !fifo_full;
  assign push        = i_valid && !fifo_full;
  assign o_tx        = tx_q;
  assign o_busy      = busy_q;
  assign o_error     = err_q;
  assign o_dbg_state = state_q;
  assign strobe      = (div_q == DIV_LAST);

  uart_transmitter_fifo #(
    .AW (FIFO_AW),
    .DW (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_x   (rst_x),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (i_data),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        div_d = strobe ? '0 : div_q + DIV_W'(1);
        if (strobe) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        div_d = strobe ? '0 : div_q + DIV_W'(1);
        if (strobe) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        div_d = strobe ? '0 : div_q + DIV_W'(1);
        // bit_q counts stop bits here; a queued byte starts with no idle gap.
        if (strobe) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_dout;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != ST_IDLE) || !fifo_empty;
      err_q   <= err_q || (i_valid && fifo_full);
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (4/1 stop, 5/2 stop, 434/1 stop), a
// byte scoreboard and a per-cycle waveform model of the expected 8N1 frame.
module tb_uart_transmitter;
  import uart_transmitter_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_x;
  logic       valid_a [3];
  logic [7:0] data_a  [3];
  logic       ready_a [3];
  logic       tx_a    [3];
  logic       busy_a  [3];
  logic       err_a   [3];
  tx_state_e  st_a    [3];

  logic [7:0] exp_q[$];
  vec_t       tbl [8];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLK_DIV(4), .FIFO_AW(2), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_x(rst_x), .i_data(data_a[0]), .i_valid(valid_a[0]),
    .o_ready(ready_a[0]), .o_tx(tx_a[0]), .o_busy(busy_a[0]), .o_error(err_a[0]),
    .o_dbg_state(st_a[0]));

  uart_transmitter #(.CLK_DIV(5), .FIFO_AW(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_x(rst_x), .i_data(data_a[1]), .i_valid(valid_a[1]),
    .o_ready(ready_a[1]), .o_tx(tx_a[1]), .o_busy(busy_a[1]), .o_error(err_a[1]),
    .o_dbg_state(st_a[1]));

  uart_transmitter #(.CLK_DIV(434), .FIFO_AW(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_x(rst_x), .i_data(data_a[2]), .i_valid(valid_a[2]),
    .o_ready(ready_a[2]), .o_tx(tx_a[2]), .o_busy(busy_a[2]), .o_error(err_a[2]),
    .o_dbg_state(st_a[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a falling edge; the push lands on the next rising edge.
  task automatic push(input int u, input logic [7:0] d);
    valid_a[u] = 1'b1;
    data_a[u]  = d;
    exp_q.push_back(d);
    @(negedge clk);
    valid_a[u] = 1'b0;
  endtask

  task automatic wait_start(input int u, input int budget, output int n);
    n = 0;
    while (tx_a[u] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", tx_a[u], 1'b0);
  endtask

  // Checks one whole frame cycle by cycle against {stop, byte, start} built from the
  // scoreboard head, and returns the mid-bit samples as a receiver would see them.
  task automatic check_frame(input int u, input int div, input int stops,
                             input bit advance, output logic [9:0] mid);
    logic [7:0] b;
    logic [9:0] model;
    logic       exp_bit;
    int         len, errs, k;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: frame seen with no byte expected at %0t", $time);
      b = 8'h00;
    end else begin
      b = exp_q.pop_front();
    end
    model = {1'b1, b, 1'b0};
    len   = (9 + stops) * div;
    errs  = 0;
    mid   = '1;
    for (int c = 0; c < len; c++) begin
      if (c > 0 || advance) @(negedge clk);
      k       = c / div;
      exp_bit = (k <= 9) ? model[k] : 1'b1;
      if (tx_a[u] !== exp_bit) errs++;
      if (k <= 9 && (c % div) == div / 2) mid[k] = tx_a[u];
    end
    check("frame_shape_errs", errs, 0);
    check("rx_byte", mid[8:1], b);
    check("rx_start_stop", {mid[9], mid[0]}, 2'b10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int          n, cnt;
    bit          rej_seen, acc;
    logic [9:0]  mid;
    time         t0, t1;

    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h55, 10'b1010101010};
    tbl[4] = '{8'hC3, 10'b1110000110};
    tbl[5] = '{8'h3C, 10'b1001111000};
    tbl[6] = '{8'h81, 10'b1100000010};
    tbl[7] = '{8'h41, 10'b1010000010};

    rst_x = 1'b0;
    for (int u = 0; u < 3; u++) begin
      valid_a[u] = 1'b0;
      data_a[u]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("reset_tx", tx_a[u], 1'b1);
      check("reset_busy", busy_a[u], 1'b0);
      check("reset_err", err_a[u], 1'b0);
      check("reset_ready", ready_a[u], 1'b1);
    end

    // Single frame: latency, bit order, length and busy release.
    push(0, tbl[0].data);
    check("no_same_cycle_pop", tx_a[0], 1'b1);
    wait_start(0, 5, n);
    check("start_latency", n, 1);
    check_frame(0, 4, 1, 1'b0, mid);
    check("t1_mid_bits", mid, tbl[0].bits);
    @(negedge clk);
    check("t1_idle_tx", tx_a[0], 1'b1);
    check("t1_busy_tail", busy_a[0], 1'b1);
    @(negedge clk);
    check("t1_busy_drop", busy_a[0], 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back frames from a burst of pushes.
    fork
      begin
        for (int i = 1; i <= 3; i++) begin
          valid_a[0] = 1'b1;
          data_a[0]  = tbl[i].data;
          exp_q.push_back(tbl[i].data);
          @(negedge clk);
        end
        valid_a[0] = 1'b0;
      end
      begin
        wait_start(0, 5, n);
        t0 = $time;
        for (int i = 1; i <= 3; i++) begin
          check_frame(0, 4, 1, (i > 1), mid);
          check("t2_mid_bits", mid, tbl[i].bits);
        end
        t1 = $time;
        check("t2_span", int'((t1 - t0) / 10) + 1, 120);
      end
    join
    @(negedge clk);
    check("t2_idle_after", tx_a[0], 1'b1);
    repeat (3) @(negedge clk);

    // Overflow while busy: 4 accepted, 2 rejected, sticky error.
    fork
      begin
        push(0, tbl[4].data);
        repeat (8) @(negedge clk);
        cnt      = 0;
        rej_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
          check("t3_ready", ready_a[0], (cnt < 4));
          check("t3_err", err_a[0], rej_seen);
          acc        = (cnt < 4);
          valid_a[0] = 1'b1;
          data_a[0]  = 8'h10 + 8'(i);
          @(negedge clk);
          if (acc) begin
            cnt++;
            exp_q.push_back(8'h10 + 8'(i));
          end else begin
            rej_seen = 1'b1;
          end
        end
        valid_a[0] = 1'b0;
        check("t3_err_set", err_a[0], 1'b1);
      end
      begin
        wait_start(0, 5, n);
        check_frame(0, 4, 1, 1'b0, mid);
        check("t3_first_bits", mid, tbl[4].bits);
      end
    join
    for (int i = 0; i < 4; i++) check_frame(0, 4, 1, 1'b1, mid);
    @(negedge clk);
    check("t3_idle_after", tx_a[0], 1'b1);
    check("t3_err_sticky", err_a[0], 1'b1);
    check("t3_sb_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of data bit 3.
    push(0, 8'h00);
    wait_start(0, 5, n);
    repeat (17) @(negedge clk);
    check("t4_pre_reset_tx", tx_a[0], 1'b0);
    #2 rst_x = 1'b0;
    #1;
    check("t4_async_tx", tx_a[0], 1'b1);
    check("t4_async_busy", busy_a[0], 1'b0);
    check("t4_async_ready", ready_a[0], 1'b1);
    check("t4_async_state", st_a[0], ST_IDLE);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    check("t4_err_cleared", err_a[0], 1'b0);
    check("t4_idle_tx", tx_a[0], 1'b1);
    push(0, tbl[5].data);
    wait_start(0, 5, n);
    check_frame(0, 4, 1, 1'b0, mid);
    check("t4_mid_bits", mid, tbl[5].bits);
    @(negedge clk);
    check("t4_idle_after", tx_a[0], 1'b1);

    // Two stop bits, CLK_DIV=5: 55-cycle frame.
    push(1, tbl[6].data);
    wait_start(1, 5, n);
    check("t5_latency", n, 1);
    check_frame(1, 5, 2, 1'b0, mid);
    check("t5_mid_bits", mid, tbl[6].bits);
    @(negedge clk);
    check("t5_idle_tx", tx_a[1], 1'b1);
    @(negedge clk);
    check("t5_busy_drop", busy_a[1], 1'b0);

    // Real 115200-baud divider.
    push(2, tbl[7].data);
    wait_start(2, 5, n);
    t0 = $time;
    check_frame(2, 434, 1, 1'b0, mid);
    t1 = $time;
    check("t6_span", int'((t1 - t0) / 10) + 1, 4340);
    check("t6_mid_bits", mid, tbl[7].bits);
    @(negedge clk);
    check("t6_idle_tx", tx_a[2], 1'b1);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
